iir_out_decim_fifo: RTL and testbench
=====================================

Name: iir_out_decim_fifo

Overview:
- Output stage directly downstream of the cascaded-SOS IIR filter.
- Consumes the filter's enable-qualified fixed-point stream and keeps one sample in every DECIM.
- Converts each kept sample to a rounded, saturated OUT_W-bit signed integer.
- Buffers results in a small show-ahead FIFO with a valid/ready output handshake, so a back-pressuring consumer (DAC/UART/bus bridge) can attach to a filter that cannot stall.

Parameters:
width_H, 15, integer bits of input fixed-point word (incl. sign)
width_W, 10, fractional bits of input word; input width = width_H+width_W
OUT_W, 12, output signed integer width, 2..width_H
DECIM, 4, decimation factor, 1..256; 1 = pass every sample
DEPTH, 4, FIFO entries, power of 2, 2..64

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
data_i_en  in  1  input sample strobe (the IIR's data_o_en)
data_i  in  width_H+width_W  signed fixed-point sample, width_W fractional bits
data_o_valid  out  1  FIFO head holds a valid sample
data_o_ready  in  1  consumer accepts head this cycle
data_o  out  OUT_W  signed integer sample at FIFO head
fill  out  $clog2(DEPTH)+1  current FIFO occupancy
ovf  out  1  sticky: a kept sample was dropped because the FIFO was full
sat  out  1  sticky: a kept sample was clipped during saturation
clr_flags  in  1  synchronous clear of ovf and sat

Behaviour:
- Reset (async assert, sync-safe deassert): data_o_valid=0, data_o=0, fill=0, ovf=0, sat=0, phase counter=0, stage register empty, FIFO pointers=0.
- Decimation
  - Phase counter cnt (0..DECIM-1) advances only on data_i_en, wrapping DECIM-1 -> 0.
  - A sample is kept iff data_i_en=1 and cnt==0.
  - data_i_en=0 changes nothing.
- Conversion of a kept sample
  - Sign-extend data_i by 1 bit and add 2^(width_W-1).
  - Arithmetic shift right by width_W (round half toward +inf).
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Any clamp sets sat.
  - Result is written to a stage register at the edge where data_i_en is sampled (edge E).
- FIFO write
  - Stage register content is written at edge E+1.
  - Write is accepted if fill<DEPTH, or if a pop occurs in the same cycle (simultaneous push/pop when full is legal; fill unchanged).
  - Otherwise the sample is dropped, ovf is set, and FIFO contents are unchanged.
- FIFO read
  - Show-ahead: data_o always reflects the head entry.
  - Pop occurs when data_o_valid && data_o_ready.
  - data_o_valid = (fill!=0).
  - data_o_ready with data_o_valid=0 has no effect.
- Latency
  - A kept sample reaches an empty FIFO with data_o_valid=1 after edge E+1: two clocks from strobe to valid.
  - A push and pop in the same cycle on an empty FIFO is impossible; the write lands first.
- fill: push only = +1, pop only = -1, both = unchanged. Never exceeds DEPTH, never underflows.
- Pointers: wrap modulo DEPTH.
- Flags: set by their events and held until clr_flags or rst. If a set event and clr_flags coincide, set wins.
- data_o is held stable while data_o_valid=1 and data_o_ready=0.
- Back-to-back strobes every clock: supported for any DECIM; throughput is 1 kept sample per DECIM strobes.
- Reset mid-operation: stage register and FIFO are discarded, and cnt returns to 0, so the first strobe after reset is kept.

Test Plan:
- Rounding (DECIM=1, ready=1): inputs 1536 (1.5), -1536 (-1.5), -1280 (-1.25), 511 -> data_o = 2, -1, -1, 0. Each output appears 2 clocks after its strobe; sat=0.
- Saturation (OUT_W=12): inputs 3000*1024 and -3000*1024 -> data_o = 2047, -2048; sat=1. clr_flags pulse -> sat=0.
- Decimation (DECIM=4): strobe k*1024 for k=0..11 with gaps of 0-3 idle clocks -> outputs exactly 0, 4, 8.
- Back-pressure/overflow (DECIM=1, DEPTH=4): ready=0, push values 1..5 -> fill=4, ovf=1; raise ready -> outputs 1, 2, 3, 4, fill returns to 0, value 5 lost.
- Full simultaneous push/pop: fill=4, ready=1 while a new sample is written -> fill stays 4, ovf stays 0, output order preserved.
- Reset mid-stream (DECIM=3, cnt=2, fill=2): pulse rst asynchronously between edges -> valid/fill/ovf/sat drop immediately to 0; the next strobe (value 7*1024) is kept and appears as 7.

Source files
------------

// File: rtl/iir_out_decim_fifo.sv
// Decimating output stage for the IIR: keeps 1 of DECIM strobed samples and rounds/saturates each kept one to OUT_W bits.
// Kept samples show up at the FIFO head two clocks after their strobe. The filter side never stalls.
// If the show-ahead FIFO is full and nothing pops, the sample is dropped and ovf is flagged.
module iir_out_decim_fifo #(
  parameter int width_H = 15,
  parameter int width_W = 10,
  parameter int OUT_W   = 12,
  parameter int DECIM   = 4,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_i_en,
  input  logic [width_H+width_W-1:0]   data_i,
  output logic                         data_o_valid,
  input  logic                         data_o_ready,
  output logic [OUT_W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]       fill,
  output logic                         ovf,
  output logic                         sat,
  input  logic                         clr_flags
);

  localparam int IN_W = width_H + width_W;
  localparam int SH_W = width_H + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [CW-1:0]   CNT_LAST = CW'(DECIM - 1);
  localparam logic [AW:0]     FULL     = {1'b1, {AW{1'b0}}};
  localparam logic [IN_W:0]   RND      = (IN_W + 1)'(1) << (width_W - 1);
  localparam logic [SH_W-1:0] MAXV     = {{(SH_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [SH_W-1:0] MINV     = {{(SH_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [CW-1:0]    r_cnt;
  logic             r_stg_vld;
  logic [OUT_W-1:0] r_stg_dat;
  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_fill;
  logic             r_ovf;
  logic             r_sat;

  logic             w_keep;
  logic [IN_W:0]    w_rnd;
  logic [SH_W-1:0]  w_int;
  logic             w_hi;
  logic             w_lo;
  logic             w_clip;
  logic [OUT_W-1:0] w_cvt;
  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic             w_drop;

  assign w_keep = data_i_en && (r_cnt == '0);

  // Sign-extend one bit so adding the half-LSB can never wrap; the upper slice is the
  // arithmetic shift by width_W, i.e. round half toward +inf.
  assign w_rnd  = {data_i[IN_W-1], data_i} + RND;
  assign w_int  = w_rnd[IN_W:width_W];
  assign w_hi   = $signed(w_int) > $signed(MAXV);
  assign w_lo   = $signed(w_int) < $signed(MINV);
  assign w_clip = w_hi || w_lo;
  assign w_cvt  = w_hi ? MAXV[OUT_W-1:0] :
                  w_lo ? MINV[OUT_W-1:0] : w_int[OUT_W-1:0];

  assign data_o_valid = (r_fill != '0);
  assign w_pop  = data_o_valid && data_o_ready;
  assign w_full = (r_fill == FULL);
  assign w_push = r_stg_vld && (!w_full || w_pop);
  assign w_drop = r_stg_vld && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_stg_vld <= 1'b0;
      r_stg_dat <= '0;
    end else begin
      if (data_i_en) begin
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
      r_stg_vld <= w_keep;
      if (w_keep) begin
        r_stg_dat <= w_cvt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_stg_dat;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as clr_flags keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_keep && w_clip) begin
        r_sat <= 1'b1;
      end else if (clr_flags) begin
        r_sat <= 1'b0;
      end
    end
  end

  assign data_o = r_mem[r_rptr];
  assign fill   = r_fill;
  assign ovf    = r_ovf;
  assign sat    = r_sat;

endmodule

// File: tb/tb_iir_out_decim_fifo.sv
// Scoreboard bench: three instances (DECIM=1, 4, 3) with directed vectors and hand-computed outputs.
module tb_iir_out_decim_fifo;

  localparam int IW = 25;

  typedef struct packed {
    int val;
    int t;
    bit lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic          a_en = 0, a_rdy = 0, a_clr = 0, a_vld, a_ovf, a_sat;
  logic [IW-1:0] a_din = '0;
  logic [11:0]   a_dout;
  logic [2:0]    a_fill;
  logic          b_en = 0, b_rdy = 0, b_clr = 0, b_vld, b_ovf, b_sat;
  logic [IW-1:0] b_din = '0;
  logic [11:0]   b_dout;
  logic [2:0]    b_fill;
  logic          c_en = 0, c_rdy = 0, c_clr = 0, c_vld, c_ovf, c_sat;
  logic [IW-1:0] c_din = '0;
  logic [11:0]   c_dout;
  logic [2:0]    c_fill;

  iir_out_decim_fifo #(.width_H(15), .width_W(10), .OUT_W(12), .DECIM(1), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .data_i_en(a_en), .data_i(a_din), .data_o_valid(a_vld),
    .data_o_ready(a_rdy), .data_o(a_dout), .fill(a_fill), .ovf(a_ovf), .sat(a_sat),
    .clr_flags(a_clr));

  iir_out_decim_fifo #(.width_H(15), .width_W(10), .OUT_W(12), .DECIM(4), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .data_i_en(b_en), .data_i(b_din), .data_o_valid(b_vld),
    .data_o_ready(b_rdy), .data_o(b_dout), .fill(b_fill), .ovf(b_ovf), .sat(b_sat),
    .clr_flags(b_clr));

  iir_out_decim_fifo #(.width_H(15), .width_W(10), .OUT_W(12), .DECIM(3), .DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .data_i_en(c_en), .data_i(c_din), .data_o_valid(c_vld),
    .data_o_ready(c_rdy), .data_o(c_dout), .fill(c_fill), .ovf(c_ovf), .sat(c_sat),
    .clr_flags(c_clr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input int act);
    chk(nm, act, e.val);
    if (e.lat) chk({nm, "_latency"}, cyc - e.t, 2);
  endtask

  task automatic extra(input string nm, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d expected=no output", nm, act);
  endtask

  // Monitors: sample mid-cycle and pop the scoreboard on every accepted head.
  always @(negedge clk) begin
    if (!rst && a_vld && a_rdy) begin
      if (qa.size() == 0) extra("a_extra", int'($signed(a_dout)));
      else cmp("a_data", qa.pop_front(), int'($signed(a_dout)));
    end
    if (!rst && b_vld && b_rdy) begin
      if (qb.size() == 0) extra("b_extra", int'($signed(b_dout)));
      else cmp("b_data", qb.pop_front(), int'($signed(b_dout)));
    end
    if (!rst && c_vld && c_rdy) begin
      if (qc.size() == 0) extra("c_extra", int'($signed(c_dout)));
      else cmp("c_data", qc.pop_front(), int'($signed(c_dout)));
    end
  end

  task automatic a_step(input logic en, input int v);
    a_en = en; a_din = IW'(v);
    @(posedge clk); #1;
    a_en = 1'b0;
  endtask

  task automatic b_step(input logic en, input int v);
    b_en = en; b_din = IW'(v);
    @(posedge clk); #1;
    b_en = 1'b0;
  endtask

  task automatic c_step(input logic en, input int v);
    c_en = en; c_din = IW'(v);
    @(posedge clk); #1;
    c_en = 1'b0;
  endtask

  task automatic a_drain();
    for (int i = 0; i < 40 && a_fill != 0; i++) a_step(1'b0, 0);
    chk("a_drain_fill", int'(a_fill), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rnd_in [4]  = '{1536, -1536, -1280, 511};
    int rnd_exp [4] = '{2, -1, -1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(a_vld), 0);
    chk("rst_dout", int'(a_dout), 0);
    chk("rst_fill", int'(a_fill), 0);
    chk("rst_ovf", int'(a_ovf), 0);
    chk("rst_sat", int'(a_sat), 0);
    rst = 1'b0;
    a_rdy = 1'b1;
    b_rdy = 1'b1;
    a_step(1'b0, 0);

    // Rounding, back-to-back strobes, 2-clock latency into an empty FIFO.
    for (int i = 0; i < 4; i++) begin
      qa.push_back('{val: rnd_exp[i], t: cyc, lat: 1'b1});
      a_step(1'b1, rnd_in[i]);
    end
    repeat (3) a_step(1'b0, 0);
    chk("round_sat", int'(a_sat), 0);

    // Saturation and flag clear.
    qa.push_back('{val: 2047, t: cyc, lat: 1'b1});
    a_step(1'b1, 3000 * 1024);
    qa.push_back('{val: -2048, t: cyc, lat: 1'b1});
    a_step(1'b1, -3000 * 1024);
    repeat (3) a_step(1'b0, 0);
    chk("sat_set", int'(a_sat), 1);
    a_clr = 1'b1;
    a_step(1'b0, 0);
    a_clr = 1'b0;
    chk("sat_clr", int'(a_sat), 0);

    // Back-pressure: fifth sample is dropped.
    a_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) qa.push_back('{val: i, t: cyc, lat: 1'b0});
      a_step(1'b1, i * 1024);
    end
    repeat (2) a_step(1'b0, 0);
    chk("ovf_fill", int'(a_fill), 4);
    chk("ovf_flag", int'(a_ovf), 1);
    chk("ovf_valid", int'(a_vld), 1);
    chk("ovf_head_held", int'($signed(a_dout)), 1);
    a_rdy = 1'b1;
    a_drain();
    a_clr = 1'b1;
    a_step(1'b0, 0);
    a_clr = 1'b0;
    chk("ovf_clr", int'(a_ovf), 0);

    // Full FIFO: stage write coincides with a pop.
    a_rdy = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      qa.push_back('{val: i, t: cyc, lat: 1'b0});
      a_step(1'b1, i * 1024);
    end
    repeat (2) a_step(1'b0, 0);
    chk("full_fill", int'(a_fill), 4);
    qa.push_back('{val: 15, t: cyc, lat: 1'b0});
    a_step(1'b1, 15 * 1024);
    a_rdy = 1'b1;
    a_step(1'b0, 0);
    a_rdy = 1'b0;
    chk("pushpop_fill", int'(a_fill), 4);
    chk("pushpop_ovf", int'(a_ovf), 0);
    a_rdy = 1'b1;
    a_drain();

    // Decimation by 4 with 0..3 idle clocks between strobes.
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) qb.push_back('{val: k, t: cyc, lat: 1'b0});
      b_step(1'b1, k * 1024);
      repeat (k % 4) b_step(1'b0, 0);
    end
    repeat (4) b_step(1'b0, 0);
    chk("decim_fill", int'(b_fill), 0);

    // Reset mid-stream on DECIM=3: five strobes leave cnt=2 with two samples queued.
    c_rdy = 1'b0;
    c_step(1'b1, 3000 * 1024);
    c_step(1'b1, 1 * 1024);
    c_step(1'b1, 2 * 1024);
    c_step(1'b1, 5 * 1024);
    c_step(1'b1, 6 * 1024);
    c_step(1'b0, 0);
    chk("c_pre_fill", int'(c_fill), 2);
    chk("c_pre_sat", int'(c_sat), 1);
    #2 rst = 1'b1;
    qa.delete(); qb.delete(); qc.delete();
    #1;
    chk("c_rst_valid", int'(c_vld), 0);
    chk("c_rst_fill", int'(c_fill), 0);
    chk("c_rst_sat", int'(c_sat), 0);
    chk("c_rst_ovf", int'(c_ovf), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    c_rdy = 1'b1;
    qc.push_back('{val: 7, t: cyc, lat: 1'b1});
    c_step(1'b1, 7 * 1024);
    repeat (4) c_step(1'b0, 0);

    chk("a_left", qa.size(), 0);
    chk("b_left", qb.size(), 0);
    chk("c_left", qc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
